// File: rtl/rf_pkg.sv
// Shared defaults and address-width derivation for the multi-port register file.
package rf_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int REG_COUNT_DEF = 32;
    localparam int NUM_RD_DEF    = 2;
    localparam int ZERO_REG_DEF  = 1;

    function automatic int addr_w(input int reg_count);
        return (reg_count > 1) ? $clog2(reg_count) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by reservation, cleared by write, reservation wins on a tie.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int  REG_COUNT = REG_COUNT_DEF,
    parameter int  NUM_RD    = NUM_RD_DEF,
    localparam int ADDR_W    = addr_w(REG_COUNT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     set_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic                     clr_i,
    input  logic [ADDR_W-1:0]        clr_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_o
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [REG_COUNT-1:0] set_mask_s;
    logic [REG_COUNT-1:0] clr_mask_s;
    logic [NUM_RD-1:0]    rd_busy_q;
    logic [NUM_RD-1:0]    rd_busy_d;

    // Next busy vector; the set mask is applied after the clear so a same-address reservation survives.
    always_comb begin
        set_mask_s = set_i ? ({{(REG_COUNT-1){1'b0}}, 1'b1} << set_addr_i) : {REG_COUNT{1'b0}};
        clr_mask_s = clr_i ? ({{(REG_COUNT-1){1'b0}}, 1'b1} << clr_addr_i) : {REG_COUNT{1'b0}};
        busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
    end

    // Read ports look at the post-update vector so they see this edge's set/clear.
    always_comb begin
        rd_busy_d = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_d[k] = busy_d[rd_addr_i[k*ADDR_W +: ADDR_W]];
        end
    end

    // Busy array and registered per-port flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q    <= {REG_COUNT{1'b0}};
            rd_busy_q <= {NUM_RD{1'b0}};
        end else begin
            busy_q    <= busy_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_busy_o = rd_busy_q;

endmodule

// File: rtl/rf_mp.sv
// Flop-based multi-read-port register file with write-through bypass and a busy scoreboard.
module rf_mp
    import rf_pkg::*;
#(
    parameter int  DATA_W    = DATA_W_DEF,
    parameter int  REG_COUNT = REG_COUNT_DEF,
    parameter int  NUM_RD    = NUM_RD_DEF,
    parameter int  ZERO_REG  = ZERO_REG_DEF,
    localparam int ADDR_W    = addr_w(REG_COUNT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     write_enabled,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     reserve_enabled,
    input  logic [ADDR_W-1:0]        reserve_addr
);

    logic                     we_s;
    logic                     rsv_s;
    logic [DATA_W-1:0]        regs_q [REG_COUNT];
    logic [DATA_W-1:0]        regs_d [REG_COUNT];
    logic [NUM_RD*DATA_W-1:0] read_data_q;
    logic [NUM_RD*DATA_W-1:0] read_data_d;
    logic [ADDR_W-1:0]        rd_addr_s;

    // Register 0 is masked out here so storage, bypass and scoreboard all ignore it.
    assign we_s  = write_enabled   && !((ZERO_REG != 0) && (write_addr   == {ADDR_W{1'b0}}));
    assign rsv_s = reserve_enabled && !((ZERO_REG != 0) && (reserve_addr == {ADDR_W{1'b0}}));

    // Storage next state.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_d[i] = (we_s && (write_addr == ADDR_W'(i))) ? write_data : regs_q[i];
        end
    end

    // Read data next state with write-through bypass.
    always_comb begin
        read_data_d = {(NUM_RD*DATA_W){1'b0}};
        rd_addr_s   = {ADDR_W{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s = read_addr[k*ADDR_W +: ADDR_W];
            read_data_d[k*DATA_W +: DATA_W] =
                (we_s && (write_addr == rd_addr_s)) ? write_data : regs_q[rd_addr_s];
        end
    end

    // Register array and registered read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            read_data_q <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
            read_data_q <= read_data_d;
        end
    end

    rf_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .NUM_RD    (NUM_RD)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_i      (rsv_s),
        .set_addr_i (reserve_addr),
        .clr_i      (we_s),
        .clr_addr_i (write_addr),
        .rd_addr_i  (read_addr),
        .rd_busy_o  (read_busy)
    );

    assign read_data = read_data_q;

endmodule

// File: doc/rf_mp.md
RF_MP -- requirements
Module: rf_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32, number of registers (power of two, 2..64); ADDR_W = log2(REG_COUNT).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 makes register 0 hardwired zero.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port read_addr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port read_data  output  NUM_RD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W].
REQ-009 SHALL have port read_busy  output  NUM_RD  registered scoreboard busy flag per read port.
REQ-010 SHALL have port write_enabled  input  1  write strobe.
REQ-011 SHALL have port write_addr  input  ADDR_W  write address.
REQ-012 SHALL have port write_data  input  DATA_W  write data.
REQ-013 SHALL have port reserve_enabled  input  1  scoreboard reservation strobe.
REQ-014 SHALL have port reserve_addr  input  ADDR_W  register to mark busy.

Function
REQ-015 Write SHALL commit write_data to register write_addr at the rising edge where write_enabled=1.
REQ-016 With ZERO_REG=1, writes and reservations to address 0 SHALL be ignored; register 0 SHALL read 0 and never busy.
REQ-017 Read latency SHALL be one cycle: read_data port k after edge N reflects read_addr k sampled at edge N.
REQ-018 Write-through bypass: if write_enabled=1 and write_addr equals read_addr k at edge N (nonzero when ZERO_REG=1), read_data k after edge N SHALL be write_data, not the old value.
REQ-019 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-020 Scoreboard: one busy bit per register; reserve_enabled=1 SHALL set busy[reserve_addr] at the edge.
REQ-021 write_enabled=1 SHALL clear busy[write_addr] at the edge.
REQ-022 Simultaneous reserve and write to the same address SHALL leave busy set (reservation wins); data is still written.
REQ-023 read_busy k after edge N SHALL equal busy[read_addr k] after that edge's updates (same bypass rule as data).
REQ-024 Reserving an already-busy register SHALL leave it busy (no counting); a write to a non-busy register SHALL leave it clear.
REQ-025 Out-of-range addresses cannot occur (REG_COUNT power of two); no error flagging.

Reset
REQ-026 While reset=1, all registers SHALL be 0, all busy bits 0, read_data 0, read_busy 0, immediately and independent of clock.
REQ-027 A write or reserve on the edge coinciding with reset=1 SHALL be discarded.
REQ-028 First edge after reset deasserts SHALL operate normally (no dead cycle).

Structure
REQ-029 Default parameter values and ADDR_W derivation SHALL reside in shared package rf_pkg.
REQ-030 Busy-bit array and its set/clear/priority logic SHALL be a sub-module rf_scoreboard (parameters REG_COUNT, NUM_RD).
REQ-031 Storage SHALL be flops (reset-clearable), not inferred RAM.

Verification
REQ-032 Reset: assert reset mid-run after writing 0xDEADBEEF to r5 -> read_data and read_busy 0 at once; read r5 after release -> 0.
REQ-033 Basic: write r7=0x12345678, next cycle read port0=r7 -> read_data[0]=0x12345678 one cycle later.
REQ-034 Bypass: same edge write r3=0xA5A5A5A5 with port0 and port1 addr 3 (old 0x1) -> both ports 0xA5A5A5A5 after the edge.
REQ-035 Zero reg: write r0=0xFFFFFFFF and reserve r0 -> read r0 gives 0, read_busy 0.
REQ-036 Scoreboard: reserve r9 -> read_busy=1 on r9; same-edge reserve+write r9=0x55 -> busy stays 1, data 0x55; plain write r9 -> busy 0.
REQ-037 Parameter sweep: DATA_W=16, REG_COUNT=8, NUM_RD=3, ZERO_REG=0 -> r0 writable (0xBEEF readback), all three ports correct.
